// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/shift/LUI ops plus a 32-iteration shift-add MULT/MULTU into HI/LO.
// Define ALU_EXEC_DIV_EN to add restoring DIV/DIVU on the same iterative FSM.
module alu_exec #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MUL_ITERS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready,
   input  logic [4:0]       ALUControl,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [4:0]       sa,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic             valid_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   localparam int unsigned CNT_W = $clog2(MUL_ITERS);
   localparam int unsigned SH_W  = $clog2(WIDTH);
   localparam int unsigned DW    = 2 * WIDTH;

   localparam logic [4:0] ALU_DEFAULT = 5'd0;
   localparam logic [4:0] ALU_AND     = 5'd1;
   localparam logic [4:0] ALU_OR      = 5'd2;
   localparam logic [4:0] ALU_XOR     = 5'd3;
   localparam logic [4:0] ALU_NOR     = 5'd4;
   localparam logic [4:0] ALU_LUI     = 5'd5;
   localparam logic [4:0] ALU_SLL     = 5'd6;
   localparam logic [4:0] ALU_SRL     = 5'd7;
   localparam logic [4:0] ALU_SRA     = 5'd8;
   localparam logic [4:0] ALU_SLLV    = 5'd9;
   localparam logic [4:0] ALU_SRLV    = 5'd10;
   localparam logic [4:0] ALU_SRAV    = 5'd11;
   localparam logic [4:0] ALU_MULT    = 5'd12;
   localparam logic [4:0] ALU_MULTU   = 5'd13;
`ifdef ALU_EXEC_DIV_EN
   localparam logic [4:0] ALU_DIV     = 5'd14;
   localparam logic [4:0] ALU_DIVU    = 5'd15;
`endif

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   wlo_q, wlo_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               accept_c, is_mul_c, sgn_c, cnt_last_c;
   logic [WIDTH-1:0]   alu_c, mag_a_c, mag_b_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [DW-1:0]      prod_c, prod_neg_c;

   assign ready      = (state_q == S_IDLE);
   assign accept_c   = valid_in && (state_q == S_IDLE);
   assign is_mul_c   = (ALUControl == ALU_MULT) || (ALUControl == ALU_MULTU);
   assign cnt_last_c = (cnt_q == CNT_W'(MUL_ITERS - 1));

`ifdef ALU_EXEC_DIV_EN
   logic               negr_q, negr_d, dz_q, dz_d;
   logic [WIDTH-1:0]   araw_q, araw_d;
   logic               is_div_c, div_take_c;
   logic [WIDTH:0]     div_sh_c;
   logic [WIDTH-1:0]   div_diff_c;

   assign is_div_c   = (ALUControl == ALU_DIV) || (ALUControl == ALU_DIVU);
   assign sgn_c      = (ALUControl == ALU_MULT) || (ALUControl == ALU_DIV);
   assign div_sh_c   = {acc_q, wlo_q[WIDTH-1]};
   assign div_take_c = (div_sh_c >= {1'b0, opb_q});
   assign div_diff_c = WIDTH'(div_sh_c - {1'b0, opb_q});
`else
   assign sgn_c      = (ALUControl == ALU_MULT);
`endif

   // Signed ops iterate on magnitudes; 0x80000000 maps to itself, which is its exact unsigned magnitude.
   assign mag_a_c    = (sgn_c && srcA[WIDTH-1]) ? (~srcA + WIDTH'(1)) : srcA;
   assign mag_b_c    = (sgn_c && srcB[WIDTH-1]) ? (~srcB + WIDTH'(1)) : srcB;
   assign mul_sum_c  = {1'b0, acc_q} + {1'b0, (wlo_q[0] ? opb_q : '0)};
   assign prod_c     = {mul_sum_c, wlo_q[WIDTH-1:1]};
   assign prod_neg_c = ~prod_c + DW'(1);

   always_comb begin
      alu_c = '0;
      case (ALUControl)
         ALU_DEFAULT: alu_c = '0;
         ALU_AND:     alu_c = srcA & srcB;
         ALU_OR:      alu_c = srcA | srcB;
         ALU_XOR:     alu_c = srcA ^ srcB;
         ALU_NOR:     alu_c = ~(srcA | srcB);
         ALU_LUI:     alu_c = {srcB[15:0], 16'h0000};
         ALU_SLL:     alu_c = srcB << sa;
         ALU_SRL:     alu_c = srcB >> sa;
         ALU_SRA:     alu_c = WIDTH'($signed(srcB) >>> sa);
         ALU_SLLV:    alu_c = srcB << srcA[SH_W-1:0];
         ALU_SRLV:    alu_c = srcB >> srcA[SH_W-1:0];
         ALU_SRAV:    alu_c = WIDTH'($signed(srcB) >>> srcA[SH_W-1:0]);
         default:     alu_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_c && is_mul_c) state_d = S_MUL;
`ifdef ALU_EXEC_DIV_EN
               if (accept_c && is_div_c) state_d = S_DIV;
`endif
            end
            S_MUL, S_DIV: if (cnt_last_c) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
         endcase
      end
   end

   // Datapath and output next-state; flush suppresses every update, including the completion write.
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      wlo_d    = wlo_q;
      opb_d    = opb_q;
      neg_d    = neg_q;
      result_d = result_q;
      valid_d  = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef ALU_EXEC_DIV_EN
      negr_d   = negr_q;
      dz_d     = dz_q;
      araw_d   = araw_q;
`endif
      if (!flush) begin
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  cnt_d = '0;
                  acc_d = '0;
                  neg_d = sgn_c && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                  if (is_mul_c) begin
                     opb_d = mag_a_c;
                     wlo_d = mag_b_c;
                  end
`ifdef ALU_EXEC_DIV_EN
                  else if (is_div_c) begin
                     opb_d  = mag_b_c;
                     wlo_d  = mag_a_c;
                     negr_d = sgn_c && srcA[WIDTH-1];
                     dz_d   = (srcB == '0);
                     araw_d = srcA;
                  end
`endif
                  else begin
                     valid_d  = 1'b1;
                     result_d = alu_c;
                  end
               end
            end
            S_MUL: begin
               acc_d = prod_c[DW-1:WIDTH];
               wlo_d = prod_c[WIDTH-1:0];
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_last_c) begin
                  valid_d      = 1'b1;
                  result_d     = '0;
                  {hi_d, lo_d} = neg_q ? prod_neg_c : prod_c;
               end
            end
`ifdef ALU_EXEC_DIV_EN
            S_DIV: begin
               acc_d = div_take_c ? div_diff_c : div_sh_c[WIDTH-1:0];
               wlo_d = {wlo_q[WIDTH-2:0], div_take_c};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_last_c) begin
                  valid_d  = 1'b1;
                  result_d = '0;
                  if (dz_q) begin
                     lo_d = '1;
                     hi_d = araw_q;
                  end else begin
                     lo_d = neg_q  ? (~wlo_d + WIDTH'(1)) : wlo_d;
                     hi_d = negr_q ? (~acc_d + WIDTH'(1)) : acc_d;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         wlo_q    <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef ALU_EXEC_DIV_EN
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         araw_q   <= '0;
`endif
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         wlo_q    <= wlo_d;
         opb_q    <= opb_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef ALU_EXEC_DIV_EN
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         araw_q   <= araw_d;
`endif
      end
   end

   assign result    = result_q;
   assign valid_out = valid_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed single-cycle, multiply, flush and reset vectors.
// Divide vectors are selected by ALU_EXEC_DIV_EN to match the DUT build.
module tb_alu_exec;
   localparam logic [4:0] ALU_DEFAULT = 5'd0;
   localparam logic [4:0] ALU_AND     = 5'd1;
   localparam logic [4:0] ALU_OR      = 5'd2;
   localparam logic [4:0] ALU_XOR     = 5'd3;
   localparam logic [4:0] ALU_NOR     = 5'd4;
   localparam logic [4:0] ALU_LUI     = 5'd5;
   localparam logic [4:0] ALU_SLL     = 5'd6;
   localparam logic [4:0] ALU_SRL     = 5'd7;
   localparam logic [4:0] ALU_SRA     = 5'd8;
   localparam logic [4:0] ALU_SLLV    = 5'd9;
   localparam logic [4:0] ALU_SRLV    = 5'd10;
   localparam logic [4:0] ALU_SRAV    = 5'd11;
   localparam logic [4:0] ALU_MULT    = 5'd12;
   localparam logic [4:0] ALU_MULTU   = 5'd13;
   localparam logic [4:0] ALU_DIV     = 5'd14;
   localparam logic [4:0] ALU_DIVU    = 5'd15;

   logic        clk = 1'b0;
   logic        rst, valid_in, flush;
   logic [4:0]  ALUControl, sa;
   logic [31:0] srcA, srcB;
   logic        ready, valid_out;
   logic [31:0] result, hi_out, lo_out;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          vo_count = 0;
   logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;

   alu_exec dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready(ready),
      .ALUControl(ALUControl), .srcA(srcA), .srcB(srcB), .sa(sa), .flush(flush),
      .result(result), .valid_out(valid_out), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Pops one expectation per valid_out pulse; a pulse with nothing pending is an error.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && valid_out) begin
            vo_count++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid_out: result=%h hi=%h lo=%h with no op pending",
                        result, hi_out, lo_out);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("%s_result", e.name), result, e.res);
               chk($sformatf("%s_hi", e.name), hi_out, e.hi);
               chk($sformatf("%s_lo", e.name), lo_out, e.lo);
            end
         end
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL wait_idle_timeout: ready=%b after %0d cycles", ready, k);
      end
   endtask

   task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s, input bit push, input bit keep,
                        input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el);
      @(posedge clk);
      #1;
      valid_in   = 1'b1;
      ALUControl = op;
      srcA       = a;
      srcB       = b;
      sa         = s;
      if (push) begin
         sb_q.push_back('{name, er, eh, el});
         m_res = er;
         m_hi  = eh;
         m_lo  = el;
      end
      @(posedge clk);
      #1;
      if (keep) begin
         srcA = 32'h1234_5678;
         srcB = 32'h0000_0000;
      end else begin
         valid_in = 1'b0;
      end
   endtask

   task automatic alu1(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s, input logic [31:0] er);
      wait_idle();
      issue(name, op, a, b, s, 1'b1, 1'b0, er, m_hi, m_lo);
      @(negedge clk);
      chk($sformatf("%s_valid", name), 32'(valid_out), 32'd1);
      chk($sformatf("%s_ready", name), 32'(ready), 32'd1);
      @(negedge clk);
      chk($sformatf("%s_single_pulse", name), 32'(valid_out), 32'd0);
   endtask

   task automatic iter_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold,
                          input logic [31:0] eh, input logic [31:0] el);
      int n = 0;
      int lows = 0;
      wait_idle();
      issue(name, op, a, b, 5'd0, 1'b1, hold, 32'h0, eh, el);
      do begin
         @(negedge clk);
         n++;
         if (!ready) lows++;
      end while (!valid_out && n < 60);
      valid_in = 1'b0;
      chk($sformatf("%s_latency", name), 32'(n), 32'd33);
      chk($sformatf("%s_busy_cycles", name), 32'(lows), 32'd33);
      @(negedge clk);
      chk($sformatf("%s_ready_after", name), 32'(ready), 32'd1);
      chk($sformatf("%s_single_pulse", name), 32'(valid_out), 32'd0);
   endtask

   initial begin
      int v0;
      rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
      ALUControl = ALU_DEFAULT; srcA = '0; srcB = '0; sa = '0;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_valid", 32'(valid_out), 32'd0);
      chk("reset_result", result, 32'h0);
      chk("reset_hi", hi_out, 32'h0);
      chk("reset_lo", lo_out, 32'h0);

      alu1("and",  ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000);
      alu1("sra",  ALU_SRA,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000);
      alu1("srlv", ALU_SRLV, 32'h4,         32'h8000_0000, 5'd0,  32'h0800_0000);
      alu1("lui",  ALU_LUI,  32'h0,         32'h0000_1234, 5'd0,  32'h1234_0000);
      alu1("or",   ALU_OR,   32'h0F0F_0000, 32'h0000_F0F0, 5'd0,  32'h0F0F_F0F0);
      alu1("xor",  ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F);
      alu1("nor",  ALU_NOR,  32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF);
      alu1("sll",  ALU_SLL,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000);
      alu1("srl",  ALU_SRL,  32'h0,         32'hF000_0000, 5'd28, 32'h0000_000F);
      alu1("sllv", ALU_SLLV, 32'h21,        32'h4000_0001, 5'd0,  32'h8000_0002);
      alu1("srav", ALU_SRAV, 32'h24,        32'h8000_0010, 5'd0,  32'hF800_0001);
      alu1("unknown", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0);

      iter_op("mult_neg",   ALU_MULT,  32'hFFFF_FFFE, 32'h3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      iter_op("multu_max",  ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              32'hFFFF_FFFE, 32'h0000_0001);
      iter_op("mult_minsq", ALU_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0,
              32'h4000_0000, 32'h0000_0000);
      iter_op("mult_min1",  ALU_MULT,  32'h8000_0000, 32'h0000_0001, 1'b0,
              32'hFFFF_FFFF, 32'h8000_0000);

      // Flush at T+10 aborts the multiply; HI/LO must keep the previous product.
      wait_idle();
      issue("mult_flushed", ALU_MULT, 32'h7, 32'h9, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_ready_next", 32'(ready), 32'd1);
      v0 = vo_count;
      repeat (40) @(negedge clk);
      chk("flush_no_valid", 32'(vo_count), 32'(v0));
      chk("flush_hi_kept", hi_out, m_hi);
      chk("flush_lo_kept", lo_out, m_lo);

      // Flush together with valid_in in IDLE drops the op.
      @(posedge clk);
      #1;
      valid_in = 1'b1; ALUControl = ALU_OR; srcA = 32'hAAAA_AAAA; srcB = 32'h5555_5555; flush = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0; flush = 1'b0;
      v0 = vo_count;
      repeat (3) @(negedge clk);
      chk("flush_idle_no_valid", 32'(vo_count), 32'(v0));
      chk("flush_idle_result", result, m_res);

`ifdef ALU_EXEC_DIV_EN
      iter_op("div_neg",   ALU_DIV,  32'hFFFF_FFF9, 32'h2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      iter_op("divu_zero", ALU_DIVU, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      iter_op("divu",      ALU_DIVU, 32'd100,       32'd7, 1'b0, 32'h0000_0002, 32'h0000_000E);
`else
      alu1("div_disabled",  ALU_DIV,  32'hFFFF_FFF9, 32'h2, 5'd0, 32'h0);
      alu1("divu_disabled", ALU_DIVU, 32'd100,       32'd7, 5'd0, 32'h0);
`endif

      // Reset at T+5 of a multiply clears everything and discards the partial product.
      wait_idle();
      issue("mult_reset", ALU_MULT, 32'h5, 32'h5, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_mid_ready", 32'(ready), 32'd1);
      chk("rst_mid_valid", 32'(valid_out), 32'd0);
      chk("rst_mid_result", result, 32'h0);
      chk("rst_mid_hi", hi_out, 32'h0);
      chk("rst_mid_lo", lo_out, 32'h0);
      v0 = vo_count;
      repeat (40) @(negedge clk);
      chk("rst_mid_no_valid", 32'(vo_count), 32'(v0));

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
